// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings, default latencies and
// the 64-bit result record.
package md_sched_pkg;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5,
    OpMfhi  = 3'd6,
    OpMflo  = 3'd7
  } md_op_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  // Multiply and divide ops occupy encodings 0..3 and run the countdown.
  function automatic logic is_long_op(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return ~op[2] & op[1];
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: produces the full {hi,lo} result for a long MD op
// and flags division by zero so the scheduler can suppress the commit.
module md_arith
  import md_sched_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output md_result_t  result,
  output logic        div_zero
);

  md_op_e      op_e;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] rt_safe;
  logic [31:0] rt_mag_safe;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic        rt_zero;

  assign op_e    = md_op_e'(op);
  assign rt_zero = (rt == 32'd0);

  assign rs_neg = rs[31];
  assign rt_neg = rt[31];
  assign rs_mag = rs_neg ? (~rs + 32'd1) : rs;
  assign rt_mag = rt_neg ? (~rt + 32'd1) : rt;

  // Keep the dividers away from a zero divisor; the result is discarded in that case anyway.
  assign rt_safe     = rt_zero ? 32'd1 : rt;
  assign rt_mag_safe = rt_zero ? 32'd1 : rt_mag;

  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  assign quo_u = rs / rt_safe;
  assign rem_u = rs % rt_safe;

  // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  assign quo_mag = rs_mag / rt_mag_safe;
  assign rem_mag = rs_mag % rt_mag_safe;
  assign quo_s   = (rs_neg ^ rt_neg) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem_s   = rs_neg ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    case (op_e)
      OpMult:  result = prod_s;
      OpMultu: result = prod_u;
      OpDiv: begin
        result.hi = rem_s;
        result.lo = quo_s;
        div_zero  = rt_zero;
      end
      OpDivu: begin
        result.hi = rem_u;
        result.lo = quo_u;
        div_zero  = rt_zero;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler: latches the result at start, counts down a fixed
// latency, then commits into HI/LO; also serves MTHI/MTLO/MFHI/MFLO and the ID stall request.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        id_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  md_op_e      op_e;
  logic        start_long;
  md_result_t  arith_result;
  logic        div_zero;

  logic [0:0]      state_q,     state_d;
  logic [CntW-1:0] count_q,     count_d;
  md_result_t      pending_q,   pending_d;
  logic            commit_ok_q, commit_ok_d;
  logic [31:0]     hi_q,        hi_d;
  logic [31:0]     lo_q,        lo_d;

  assign op_e       = md_op_e'(md_op);
  assign start_long = ex_start & is_long_op(md_op);

  md_arith u_md_arith (
    .op       (md_op),
    .rs       (rs_data),
    .rt       (rt_data),
    .result   (arith_result),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pending_d   = pending_q;
    commit_ok_d = commit_ok_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      StIdle: begin
        if (start_long) begin
          state_d     = StRun;
          count_d     = is_div_op(md_op) ? DivLoad : MultLoad;
          pending_d   = arith_result;
          commit_ok_d = ~div_zero;
        end else if (ex_start && op_e == OpMthi) begin
          hi_d = rs_data;
        end else if (ex_start && op_e == OpMtlo) begin
          lo_d = rs_data;
        end
      end
      StRun: begin
        // Any ex_start seen here is ignored; ID is stalled while busy.
        if (count_q == '0) begin
          state_d = StIdle;
          if (commit_ok_q) begin
            hi_d = pending_q.hi;
            lo_d = pending_q.lo;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      pending_q   <= '0;
      commit_ok_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      commit_ok_q <= commit_ok_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign stall_req = id_md_use & (busy | start_long);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign rd_data   = (op_e == OpMfhi) ? hi_q : lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed vector table, reset-abort sequence and random
// ops compared against a longint arithmetic reference model.
module tb_md_sched;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        id_md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  md_sched #(
    .MULT_CYCLES (MultN),
    .DIV_CYCLES  (DivN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ex_start  (ex_start),
    .md_op     (md_op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .id_md_use (id_md_use),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, Verilog semantics truncate toward zero.
  task automatic model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] h0, input logic [31:0] l0,
                       output logic [31:0] h, output logic [31:0] l);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    h  = h0;
    l  = l0;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    case (op)
      3'd0: begin sp = sa * sb; {h, l} = sp; end
      3'd1: begin up = ua * ub; {h, l} = up; end
      3'd2: if (rt != 0) begin
        sp = sa / sb; l = sp[31:0];
        sp = sa % sb; h = sp[31:0];
      end
      3'd3: if (rt != 0) begin l = rs / rt; h = rs % rt; end
      3'd4: h = rs;
      3'd5: l = rs;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic iu, input bit noisy,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int unsigned n;
    @(negedge clk);
    ex_start  = 1'b1;
    md_op     = op;
    rs_data   = rs;
    rt_data   = rt;
    id_md_use = iu;
    #1;
    check("stall_start", {63'd0, stall_req}, {63'd0, iu & (op <= 3'd3)});
    if (op >= 3'd6) check("rd_data", {32'd0, rd_data}, {32'd0, (op == 3'd6) ? cur_hi : cur_lo});
    if (op <= 3'd3) begin
      n = op[1] ? DivN : MultN;
      for (int k = 0; k < int'(n); k++) begin
        @(posedge clk);
        #1;
        check("busy_run", {63'd0, busy}, 64'd1);
        check("hilo_hold", {hi, lo}, {cur_hi, cur_lo});
        check("stall_busy", {63'd0, stall_req}, {63'd0, iu});
        // Starts arriving while busy must be ignored.
        if (noisy && k < int'(n) - 1) begin
          ex_start = 1'($urandom_range(0, 1));
          md_op    = 3'($urandom_range(0, 7));
          rs_data  = $urandom;
          rt_data  = $urandom;
        end else begin
          ex_start = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
      ex_start = 1'b0;
      #1;
    end
    check("busy_idle", {63'd0, busy}, 64'd0);
    check("stall_idle", {63'd0, stall_req}, 64'd0);
    check("hilo_result", {hi, lo}, {exp_hi, exp_lo});
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] rs, rt, eh, el;

    tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3]  = '{3'd3, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[5]  = '{3'd4, 32'h00001234, 32'h00000000, 32'h00001234, 32'h80000000};
    tbl[6]  = '{3'd6, 32'h00000000, 32'h00000000, 32'h00001234, 32'h80000000};
    tbl[7]  = '{3'd5, 32'h00005678, 32'h00000000, 32'h00001234, 32'h00005678};
    tbl[8]  = '{3'd7, 32'h00000000, 32'h00000000, 32'h00001234, 32'h00005678};
    tbl[9]  = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    tbl[10] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[11] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    reset     = 1'b1;
    ex_start  = 1'b0;
    md_op     = 3'd0;
    rs_data   = '0;
    rt_data   = '0;
    id_md_use = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_stall", {63'd0, stall_req}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].op, tbl[i].rs, tbl[i].rt, 1'(i % 2 == 0), 1'b0, tbl[i].hi, tbl[i].lo);
    end

    // Reset during the third busy cycle of a divide aborts it with nothing committed.
    @(negedge clk);
    ex_start = 1'b1;
    md_op    = 3'd2;
    rs_data  = 32'd1000;
    rt_data  = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    ex_start = 1'b0;
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (DivN + 2) @(posedge clk);
    #1;
    check("abort_no_commit", {hi, lo}, 64'd0);
    check("abort_idle", {63'd0, busy}, 64'd0);
    cur_hi = '0;
    cur_lo = '0;

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0:       rt = 32'd0;
        1:       rt = $urandom_range(1, 9);
        2:       rt = 32'hFFFFFFFF - 32'($urandom_range(0, 8));
        default: rt = $urandom;
      endcase
      model(op, rs, rt, cur_hi, cur_lo, eh, el);
      do_op(op, rs, rt, 1'($urandom_range(0, 1)), 1'b1, eh, el);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
